// File: rtl/univ_binary_counter.sv
// rtl/univ_binary_counter.sv - N-bit universal up/down counter with load, terminal value and sticky overflow
module univ_binary_counter #(
    parameter int N        = 8,
    parameter int SATURATE = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         syn_clr,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic [N-1:0] d,
    input  logic [N-1:0] limit,
    output logic [N-1:0] q,
    output logic         max_tick,
    output logic         min_tick,
    output logic         ovf
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] q_next;
    logic         ovf_next;

    always_comb begin
        q_next   = q;
        ovf_next = ovf;
        if (syn_clr) begin
            q_next   = '0;
            ovf_next = 1'b0;
        end else if (load) begin
            q_next = d;
        end else if (en) begin
            if (up) begin
                // q above limit (late load or lowered limit) is treated as the top bound
                if (q >= limit) begin
                    q_next   = (SATURATE != 0) ? q : '0;
                    ovf_next = 1'b1;
                end else begin
                    q_next = q + ONE;
                end
            end else begin
                if (q == '0) begin
                    q_next   = (SATURATE != 0) ? '0 : limit;
                    ovf_next = 1'b1;
                end else begin
                    q_next = q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q   <= '0;
            ovf <= 1'b0;
        end else begin
            q   <= q_next;
            ovf <= ovf_next;
        end
    end

    assign max_tick = (q == limit);
    assign min_tick = (q == '0);

endmodule

// File: tb/tb_univ_binary_counter.sv
// tb/tb_univ_binary_counter.sv - directed table and sequence checks for univ_binary_counter
module tb_univ_binary_counter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       syn_clr, load, en, up;
    logic [7:0] d, limit;
    logic [3:0] d4, limit4;

    logic [7:0] q0, q1;
    logic [3:0] q4;
    logic       mx0, mn0, ovf0, mx1, mn1, ovf1, mx4, mn4, ovf4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    univ_binary_counter #(.N(8), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .syn_clr(syn_clr), .load(load), .en(en), .up(up),
        .d(d), .limit(limit), .q(q0), .max_tick(mx0), .min_tick(mn0), .ovf(ovf0)
    );

    univ_binary_counter #(.N(8), .SATURATE(1)) dut_sat (
        .clk(clk), .reset_n(reset_n), .syn_clr(syn_clr), .load(load), .en(en), .up(up),
        .d(d), .limit(limit), .q(q1), .max_tick(mx1), .min_tick(mn1), .ovf(ovf1)
    );

    univ_binary_counter #(.N(4), .SATURATE(0)) dut_n4 (
        .clk(clk), .reset_n(reset_n), .syn_clr(syn_clr), .load(load), .en(en), .up(up),
        .d(d4), .limit(limit4), .q(q4), .max_tick(mx4), .min_tick(mn4), .ovf(ovf4)
    );

    typedef struct {
        logic       sc;
        logic       ld;
        logic       en;
        logic       up;
        logic [7:0] d;
        logic [7:0] lim;
        logic [7:0] q_w;
        logic       o_w;
        logic [7:0] q_s;
        logic       o_s;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // sc ld en up d lim | wrap q,ovf | sat q,ovf
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd5,   8'd9, 8'd5,   1'b0, 8'd5,   1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'd7,   8'd9, 8'd0,   1'b0, 8'd0,   1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd7,   8'd9, 8'd7,   1'b0, 8'd7,   1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd9, 8'd8,   1'b0, 8'd8,   1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd9, 8'd9,   1'b0, 8'd9,   1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd9, 8'd0,   1'b1, 8'd9,   1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0,   8'd9, 8'd0,   1'b1, 8'd9,   1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd9, 8'd9,   1'b1, 8'd8,   1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd9, 8'd0,   1'b0, 8'd0,   1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd200, 8'd9, 8'd200, 1'b0, 8'd200, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd9, 8'd0,   1'b1, 8'd200, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd9, 8'd0,   1'b0, 8'd0,   1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd0, 8'd0,   1'b1, 8'd0,   1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd9, 8'd0,   1'b0, 8'd0,   1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd9, 8'd9,   1'b1, 8'd0,   1'b1};

        reset_n = 1'b0;
        {syn_clr, load, en, up} = 4'b0;
        d = 8'd0; limit = 8'd9; d4 = 4'd0; limit4 = 4'd15;
        step();
        chk("reset_q", q0, 8'd0);
        chk("reset_ovf", ovf0, 1'b0);
        chk("reset_min", mn0, 1'b1);
        chk("reset_max", mx0, 1'b0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 15; i++) begin
            syn_clr = vecs[i].sc; load = vecs[i].ld; en = vecs[i].en; up = vecs[i].up;
            d = vecs[i].d; limit = vecs[i].lim;
            step();
            chk($sformatf("vec%0d_q_wrap", i), q0, vecs[i].q_w);
            chk($sformatf("vec%0d_ovf_wrap", i), ovf0, vecs[i].o_w);
            chk($sformatf("vec%0d_q_sat", i), q1, vecs[i].q_s);
            chk($sformatf("vec%0d_ovf_sat", i), ovf1, vecs[i].o_s);
            chk($sformatf("vec%0d_max_wrap", i), mx0, vecs[i].q_w == vecs[i].lim);
            chk($sformatf("vec%0d_min_sat", i), mn1, vecs[i].q_s == 8'd0);
        end

        // async reset in the middle of a count
        {syn_clr, load, en, up} = 4'b0100;
        d = 8'h5A; limit = 8'hFF;
        step();
        chk("preload_q", q0, 8'h5A);
        load = 1'b0; en = 1'b1; up = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("async_q", q0, 8'd0);
        chk("async_ovf", ovf0, 1'b0);
        chk("async_min", mn0, 1'b1);
        step();
        chk("held_in_reset_q", q0, 8'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("post_reset_q", q0, 8'd3);

        // wrap up through limit 9
        {syn_clr, load, en, up} = 4'b1000;
        limit = 8'd9;
        step();
        {syn_clr, load, en, up} = 4'b0011;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk($sformatf("wrap_q_%0d", i), q0, i % 10);
            chk($sformatf("wrap_max_%0d", i), mx0, (i % 10) == 9);
            chk($sformatf("wrap_ovf_%0d", i), ovf0, i == 10);
        end
        en = 1'b0;
        step(); step();
        chk("wrap_ovf_sticky", ovf0, 1'b1);
        chk("wrap_hold_q", q0, 8'd0);
        syn_clr = 1'b1;
        step();
        chk("wrap_ovf_clr", ovf0, 1'b0);

        // saturating down count from 2
        {syn_clr, load, en, up} = 4'b0100;
        d = 8'd2;
        step();
        {syn_clr, load, en, up} = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("satdn_q_%0d", i), q1, (i == 0) ? 8'd1 : 8'd0);
            chk($sformatf("satdn_ovf_%0d", i), ovf1, i >= 2);
            chk($sformatf("satdn_min_%0d", i), mn1, i >= 1);
        end

        // full 4-bit range wraps both ways
        {syn_clr, load, en, up} = 4'b1000;
        step();
        {syn_clr, load, en, up} = 4'b0010;
        limit4 = 4'd15;
        step();
        chk("n4_down_q", q4, 4'd15);
        chk("n4_down_ovf", ovf4, 1'b1);
        chk("n4_max", mx4, 1'b1);
        up = 1'b1;
        step();
        chk("n4_up_q", q4, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/univ_binary_counter.md
Name: univ_binary_counter

Overview:
Parametrised N-bit universal binary counter, successor to the free-running 8-bit counter with max tick. Adds synchronous clear, parallel load, count enable, up/down direction, a programmable terminal value and selectable wrap/saturate mode. Adds a sticky overflow flag. Used as a general timebase and event counter in the class designs, e.g. feeding baud/tick generators and display multiplexers.

Parameters:
N, 8, counter width in bits (N >= 2).
SATURATE, 0, 0 = wrap at bounds; 1 = hold at bounds.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
syn_clr  input  1  synchronous clear, highest synchronous priority
load  input  1  synchronous parallel load of d
en  input  1  count enable
up  input  1  direction: 1 = increment, 0 = decrement
d  input  N  parallel load value
limit  input  N  terminal (top) count; counting range is 0..limit
q  output  N  current count (registered)
max_tick  output  1  high while q == limit
min_tick  output  1  high while q == 0
ovf  output  1  sticky flag: a wrap or saturation event has occurred

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset_n` is asynchronous and active-low.
  - reset_n low → q = 0 and ovf = 0 immediately, with no clock edge needed.
  - Consequently max_tick = (limit == 0) and min_tick = 1 during reset.
- Per-edge priority on the rising edge of clk, first match wins:
  - syn_clr = 1 → q <= 0, ovf <= 0.
  - load = 1 → q <= d, ovf unchanged. No range check: d > limit is accepted as loaded.
  - en = 1, up = 1:
    - If q >= limit: q <= 0 when SATURATE = 0, or q <= q (hold) when SATURATE = 1; ovf <= 1 in both cases.
    - Otherwise q <= q + 1.
  - en = 1, up = 0:
    - If q == 0: q <= limit when SATURATE = 0, or q <= 0 (hold) when SATURATE = 1; ovf <= 1 in both cases.
    - Otherwise q <= q - 1.
  - en = 0 → hold q and ovf.
- Out-of-range up-count: q > limit (after a load, or after limit was lowered) counts as q >= limit. An up-count from there wraps to 0 or holds; it never counts past limit toward 2^N-1.
- Width: all arithmetic is N bits, unsigned. With limit = 2^N-1 and SATURATE = 0 the block behaves as a plain modulo-2^N counter.
- Flags:
  - max_tick and min_tick are combinational decodes of the registered q and the current limit. There is no added latency and they are not gated by en.
  - When limit == 0, both ticks are high at q = 0. An enabled count in either direction produces the bound event (q stays 0, ovf set).
- Latency: q changes exactly one edge after the qualifying control is sampled. ovf sets on the same edge as the wrap or hold.
- Simultaneous controls: syn_clr with load/en → clear. load with en → load only; d is not incremented.
- limit change mid-count: takes effect on the next edge. No internal copy of limit is kept.
- Asynchronous reset mid-count overrides everything. Counting resumes from 0 on the first edge after reset_n deasserts.
- Inputs are synchronous to clk. No internal synchronisers.

Test Plan:
- Reset: N = 8, hold reset_n = 0 mid-count with q = 8'h5A → q = 0 and ovf = 0 asynchronously; min_tick = 1. After release, en = 1 and up = 1 for 3 edges → q = 3.
- Wrap up: N = 8, SATURATE = 0, limit = 9, en = 1, up = 1 from 0 for 10 edges → q runs 1..9 then 0. max_tick is high only while q = 9; ovf = 1 after the 10th edge and stays 1 until syn_clr.
- Saturate down: SATURATE = 1, limit = 9, load d = 2, then en = 1, up = 0 for 4 edges → q = 1, 0, 0, 0. ovf is set on the 3rd edge; min_tick stays high from the 2nd edge.
- Priority: set q = 5, then assert syn_clr = 1, load = 1 (d = 7) and en = 1 together → q = 0, ovf = 0. Then load = 1 with en = 1 and d = 7 → q = 7, not 8.
- Out of range: limit = 9, load d = 200, then en = 1, up = 1 → q = 0 (SATURATE = 0) with ovf = 1. Repeat with SATURATE = 1 → q holds at 200 with ovf = 1.
- Full range: N = 4, limit = 15, SATURATE = 0, up = 0 from q = 0 → q = 15 with ovf = 1. Then up = 1 → q = 0.
